// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset vector and fetch state encoding
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;

  // The PC resets to this address too, so the first fetch always lands here.
  localparam logic [CPU_ADDR_W-1:0] RESET_VECTOR = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - WAIT-cycle counter that flags a stalled memory read
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != CNT_W'(TIMEOUT))) begin
      count <= count + CNT_W'(1);
    end
  end

  // count holds the WAIT cycles already spent, so the TIMEOUT-th stalled cycle fires.
  assign expired = count_en && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch FSM driving the PC; FETCH_TIMEOUT_EN adds a WAIT timeout
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = CPU_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] next_address,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              dec_ready,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              fetch_err
);

  fetch_state_t state, state_nxt;
  logic         capture;
  logic         timeout_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (mem_ready) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end else if (timeout_hit) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_HOLD: begin
        if (dec_ready) begin
          state_nxt = halt ? ST_HALTED : ST_REQ;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr <= '0;
    end else if (capture) begin
      instr <= mem_rdata;
    end
  end

  assign mem_rd      = (state == ST_REQ) || (state == ST_WAIT);
  assign mem_addr    = mem_rd ? pc_addr : ADDR_W'(RESET_VECTOR);
  assign instr_valid = (state == ST_HOLD);

  // The PC loads every edge, so anything but an accepted, non-halting HOLD must echo pc_addr.
  always_comb begin
    next_address = pc_addr;
    if ((state == ST_HOLD) && dec_ready && !halt) begin
      next_address = branch_take ? branch_target : pc_addr + ADDR_W'(1);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic fetch_err_q;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    ((state == ST_REQ) && !mem_ready),
    .count_en ((state == ST_WAIT) && !mem_ready),
    .expired  (timeout_hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_err_q <= 1'b0;
    end else if (timeout_hit) begin
      fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT only matters with the counter built in; it is folded away here.
  assign fetch_err   = 1'b0 & (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer with a PC and memory model
module tb_fetch_sequencer;

  localparam int TB_TIMEOUT = 15;

  logic       clock;
  logic       reset_n;
  logic [7:0] pc_addr;
  logic [7:0] next_address;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       dec_ready;
  logic       branch_take;
  logic [7:0] branch_target;
  logic       halt;
  logic       fetch_err;

  logic [7:0] mem [256];
  int         rd_age;
  int         lat_cfg;
  logic [7:0] exp_pc;
  int         n_checks;
  int         n_fail;

  fetch_sequencer #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pc_addr       (pc_addr),
    .next_address  (next_address),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .dec_ready     (dec_ready),
    .branch_take   (branch_take),
    .branch_target (branch_target),
    .halt          (halt),
    .fetch_err     (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program counter model: loads next_address every edge, resets to 0x00.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc_addr <= 8'h00;
    else          pc_addr <= next_address;
  end

  // Memory model: ready once the read has been held for lat_cfg cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    rd_age <= 0;
    else if (mem_rd) rd_age <= rd_age + 1;
    else             rd_age <= 0;
  end
  assign mem_ready = mem_rd && (rd_age >= lat_cfg);
  assign mem_rdata = mem[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dec_ready = 1'b0; branch_take = 1'b0; halt = 1'b0; branch_target = 8'h00;
    lat_cfg = 0;
    step();
    step();
    check_eq("rst_mem_rd", mem_rd, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_err", fetch_err, 0);
    check_eq("rst_next", next_address, pc_addr);
    reset_n = 1'b1;
    exp_pc = 8'h00;
  endtask

  // One fetch/decode transaction: wait for instr_valid, stall the decoder for dly cycles, accept.
  task automatic fetch_one(input int lat, input int first, input int dly,
                           input bit br, input logic [7:0] tgt, input bit hl);
    int n;
    logic [7:0] nxt;
    n = 0;
    lat_cfg = lat;
    while (!instr_valid && n < lat + 10) begin
      if (mem_rd) begin
        check_eq("mem_addr", mem_addr, exp_pc);
        check_eq("pc_hold", pc_addr, exp_pc);
      end
      step();
      n++;
    end
    check_eq("valid", instr_valid, 1);
    check_eq("latency", n, lat + 1 + first);
    check_eq("instr", instr, mem[exp_pc]);
    for (int i = 0; i < dly; i++) begin
      dec_ready = 1'b0;
      branch_take = 1'($urandom);
      halt = 1'($urandom);
      branch_target = 8'($urandom);
      #1;
      check_eq("stall_next", next_address, pc_addr);
      check_eq("stall_valid", instr_valid, 1);
      check_eq("stall_instr", instr, mem[exp_pc]);
      step();
    end
    dec_ready = 1'b1; branch_take = br; branch_target = tgt; halt = hl;
    #1;
    nxt = hl ? exp_pc : (br ? tgt : exp_pc + 8'd1);
    check_eq("next_address", next_address, nxt);
    step();
    dec_ready = 1'b0; branch_take = 1'b0; halt = 1'b0;
    exp_pc = nxt;
    check_eq("pc", pc_addr, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    lat_cfg = 0;
    reset_n = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);

    do_reset();
    // Zero-wait sequential stream from the reset vector.
    fetch_one(0, 1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++) fetch_one(0, 0, 0, 0, 8'h00, 0);
    check_eq("seq_pc", pc_addr, 8'h06);

    // Wrap 0xFF -> 0x00.
    fetch_one(0, 0, 0, 1, 8'hFF, 0);
    fetch_one(0, 0, 0, 0, 8'h00, 0);
    check_eq("wrap_pc", pc_addr, 8'h00);

    // Branch after decoder stalls carrying stray branch/halt requests.
    fetch_one(0, 0, 2, 1, 8'h40, 0);
    check_eq("branch_pc", pc_addr, 8'h40);
    fetch_one(3, 0, 0, 0, 8'h00, 0);

    for (int k = 0; k < 30; k++) begin
      fetch_one($urandom_range(0, 4), 0, $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0), 8'($urandom), 0);
    end

    // Halt wins over branch and freezes everything.
    fetch_one(1, 0, 0, 1, 8'h77, 1);
    for (int k = 0; k < 20; k++) begin
      dec_ready = 1'($urandom); branch_take = 1'($urandom); branch_target = 8'($urandom);
      #1;
      check_eq("halt_rd", mem_rd, 0);
      check_eq("halt_valid", instr_valid, 0);
      check_eq("halt_next", next_address, exp_pc);
      step();
    end
    check_eq("halt_pc", pc_addr, exp_pc);

    // Reset mid-WAIT restarts fetch at 0x00.
    do_reset();
    fetch_one(0, 1, 0, 1, 8'h90, 0);
    lat_cfg = 1000;
    repeat (3) step();
    check_eq("wait_rd", mem_rd, 1);
    check_eq("wait_addr", mem_addr, 8'h90);
    check_eq("wait_valid", instr_valid, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_rd", mem_rd, 0);
    check_eq("arst_valid", instr_valid, 0);
    check_eq("arst_pc", pc_addr, 8'h00);
    step();
    reset_n = 1'b1;
    exp_pc = 8'h00;
    lat_cfg = 0;
    fetch_one(0, 1, 0, 0, 8'h00, 0);

    // Memory that never answers.
    lat_cfg = 100000;
`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!fetch_err && n < TB_TIMEOUT + 10) begin
        step();
        n++;
      end
      check_eq("to_err", fetch_err, 1);
      check_eq("to_cycles", n, TB_TIMEOUT + 1);
      check_eq("to_rd", mem_rd, 0);
      check_eq("to_valid", instr_valid, 0);
      repeat (5) step();
      check_eq("to_sticky", fetch_err, 1);
      check_eq("to_rd_after", mem_rd, 0);
    end
`else
    repeat (40) step();
    check_eq("nto_rd", mem_rd, 1);
    check_eq("nto_addr", mem_addr, exp_pc);
    check_eq("nto_err", fetch_err, 0);
    check_eq("nto_valid", instr_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
